// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : 2**REGBITS x WIDTH register file, two combinational read
//               ports and one synchronous write port feeding the ALU a/b
//               operands. Optional write-to-read forwarding is enabled by
//               defining the macro REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               regwrite,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2
);

    localparam int c_DEPTH = 2 ** REGBITS;

    logic [WIDTH-1:0] r_mem_q [c_DEPTH];
    logic [WIDTH-1:0] w_mem_d [c_DEPTH];

    // Next-state array: only the addressed entry takes the write data.
    always_comb begin
        for (int i = 0; i < c_DEPTH; i++) begin
            w_mem_d[i] = r_mem_q[i];
        end
        if (regwrite) begin
            w_mem_d[wa] = wd;
        end
    end

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    // Each port forwards independently; no forwarding while reset is held.
    always_comb begin
        w_fwd1 = regwrite && !reset && (ra1 == wa);
        w_fwd2 = regwrite && !reset && (ra2 == wa);
        rd1    = w_fwd1 ? wd : r_mem_q[ra1];
        rd2    = w_fwd2 ? wd : r_mem_q[ra2];
    end
`else
    always_comb begin
        rd1 = r_mem_q[ra1];
        rd2 = r_mem_q[ra2];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module      : tb_regfile
// Description : Self-checking bench for regfile: directed cases followed by
//               randomized traffic compared against an array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

    logic        clk;
    logic        reset;
    logic        regwrite;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] rd1;
    logic [15:0] rd2;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [16];

    regfile #(
        .WIDTH   (16),
        .REGBITS (4)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .regwrite (regwrite),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value for the current input state.
    function automatic logic [15:0] exp_rd(input logic [3:0] addr);
`ifdef REGFILE_BYPASS_EN
        if (regwrite && !reset && addr == wa) return wd;
`endif
        return model[addr];
    endfunction

    task automatic check_reads(input string tag);
        #1;
        check({tag, ".rd1"}, rd1, exp_rd(ra1));
        check({tag, ".rd2"}, rd2, exp_rd(ra2));
    endtask

    // One clock cycle with the given controls; returns at the following negedge.
    task automatic step(input logic rst, input logic we, input logic [3:0] a, input logic [15:0] d);
        reset    = rst;
        regwrite = we;
        wa       = a;
        wd       = d;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        end else if (we) begin
            model[a] = d;
        end
        @(negedge clk);
        reset    = 1'b0;
        regwrite = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        regwrite = 1'b0;
        wa       = '0;
        wd       = '0;
        ra1      = '0;
        ra2      = '0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        @(negedge clk);
        step(1'b1, 1'b0, 4'd0, 16'h0000);

        // Reset drops a concurrent write and clears everything
        step(1'b0, 1'b1, 4'd3, 16'h1234);
        ra1 = 4'd3;
        #1 check("preload_r3", rd1, 16'h1234);
        step(1'b1, 1'b1, 4'd3, 16'hFFFF);
        #1 check("reset_r3", rd1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            #1;
            check("reset_all.rd1", rd1, 16'h0000);
            check("reset_all.rd2", rd2, 16'h0000);
        end

        // Basic write/read, no extra latency
        step(1'b0, 1'b1, 4'd5, 16'hA5A5);
        step(1'b0, 1'b1, 4'd9, 16'h5A5A);
        ra1 = 4'd5;
        ra2 = 4'd9;
        #1;
        check("basic.rd1", rd1, 16'hA5A5);
        check("basic.rd2", rd2, 16'h5A5A);

        // Same address on both ports; disabled write leaves r9 alone
        ra1 = 4'd9;
        #1;
        check("same.rd1", rd1, 16'h5A5A);
        check("same.rd2", rd2, 16'h5A5A);
        step(1'b0, 1'b0, 4'd9, 16'h0000);
        #1 check("nowrite_r9", rd1, 16'h5A5A);

        // Read during write
        step(1'b0, 1'b1, 4'd2, 16'h0001);
        ra1      = 4'd2;
        regwrite = 1'b1;
        wa       = 4'd2;
        wd       = 16'h0002;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before", rd1, 16'h0002);
`else
        check("rdw_before", rd1, 16'h0001);
`endif
        step(1'b0, 1'b1, 4'd2, 16'h0002);
        #1 check("rdw_after", rd1, 16'h0002);

        // Back-to-back writes to the top address
        step(1'b0, 1'b1, 4'd15, 16'hFFFF);
        step(1'b0, 1'b1, 4'd15, 16'h8000);
        ra2 = 4'd15;
        ra1 = 4'd14;
        #1;
        check("b2b_r15", rd2, 16'h8000);
        check("r14_untouched", rd1, 16'h0000);

        // ALU subtract writeback: r4 = r1 - r2
        step(1'b0, 1'b1, 4'd1, 16'h0007);
        step(1'b0, 1'b1, 4'd2, 16'h0003);
        ra1 = 4'd1;
        ra2 = 4'd2;
        #1;
        check("alu_a", rd1, 16'h0007);
        check("alu_b", rd2, 16'h0003);
        step(1'b0, 1'b1, 4'd4, 16'h0007 - 16'h0003);
        ra1 = 4'd4;
        #1 check("alu_wb_r4", rd1, 16'h0004);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 39) == 0);
            regwrite = 1'($urandom);
            wa       = 4'($urandom);
            wd       = 16'($urandom);
            ra1      = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
            ra2      = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
            check_reads("rnd");
            ra1 = 4'($urandom);
            check_reads("rnd_addr_change");
            step(reset, regwrite, wa, wd);
        end

        // Final sweep of every entry
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(i);
            check_reads("sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
